// File: rtl/billiard_pkg.sv
// Shared types for the billiard velocity path.
// Contents:
//   VELOCITY_W  width of a signed velocity component
//   BALL_ID_W   width of a ball index (covers up to 16 balls)
//   velocity_t  11-bit two's complement velocity component
//   ball_id_t   ball index
//   vel_req_t   one pending velocity update {id, vx, vy}
package billiard_pkg;

   localparam int VELOCITY_W = 11;
   localparam int BALL_ID_W  = 4;

   typedef logic signed [VELOCITY_W-1:0] velocity_t;
   typedef logic [BALL_ID_W-1:0]         ball_id_t;

   typedef struct packed {
      ball_id_t  id;
      velocity_t vx;
      velocity_t vy;
   } vel_req_t;

endpackage

// File: rtl/ball_velocity_scheduler_if.sv
// Bundle between velocity requesters / balls and the velocity scheduler.
// Signals:
//   startOfFrame         1-cycle frame pulse
//   reqValid/reqReady    per-requester handshake (accept on valid & ready)
//   reqBallId            target ball per requester
//   reqVelX/reqVelY      new velocity per requester
//   ballStopped          per-ball at-rest flags
//   velocityWriteEnable  one-hot write strobe to the balls
//   outVelocityX/Y       shared velocity bus, valid while a strobe is high
//   frameTickOut         delayed frame pulse used by the balls
//   allStopped           debounced all-balls-at-rest
//   badIdPulse           granted request targeted a non-existent ball
// Modports: master = requester/ball side, slave = scheduler.
interface ball_velocity_scheduler_if #(
   parameter int NUM_REQ   = 4,
   parameter int NUM_BALLS = 16
);

   logic                                  startOfFrame;
   logic [NUM_REQ-1:0]                    reqValid;
   logic [NUM_REQ-1:0]                    reqReady;
   billiard_pkg::ball_id_t  [NUM_REQ-1:0] reqBallId;
   billiard_pkg::velocity_t [NUM_REQ-1:0] reqVelX;
   billiard_pkg::velocity_t [NUM_REQ-1:0] reqVelY;
   logic [NUM_BALLS-1:0]                  ballStopped;
   logic [NUM_BALLS-1:0]                  velocityWriteEnable;
   billiard_pkg::velocity_t               outVelocityX;
   billiard_pkg::velocity_t               outVelocityY;
   logic                                  frameTickOut;
   logic                                  allStopped;
   logic                                  badIdPulse;

   modport master (
      output startOfFrame, reqValid, reqBallId, reqVelX, reqVelY, ballStopped,
      input  reqReady, velocityWriteEnable, outVelocityX, outVelocityY,
             frameTickOut, allStopped, badIdPulse
   );

   modport slave (
      input  startOfFrame, reqValid, reqBallId, reqVelX, reqVelY, ballStopped,
      output reqReady, velocityWriteEnable, outVelocityX, outVelocityY,
             frameTickOut, allStopped, badIdPulse
   );

endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with an internal search pointer.
// Ports:
//   clk      system clock
//   reset    asynchronous active-high reset (pointer -> 0)
//   req      request vector
//   advance  a grant was taken this cycle; moves the pointer past the winner
//   grant    one-hot grant (combinational), zero when no request
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         advance,
   output logic [N-1:0] grant
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   // ptr_reg is the first index searched, i.e. last winner + 1.
   logic [PW-1:0] ptr_reg;
   logic [PW-1:0] win_idx;
   logic          found;
   int            idx;

   always_comb begin
      grant   = '0;
      win_idx = '0;
      found   = 1'b0;
      idx     = 0;
      for (int k = 0; k < N; k++) begin
         idx = (int'(ptr_reg) + k) % N;
         if (!found && req[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            win_idx    = idx[PW-1:0];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ptr_reg <= '0;
      end else if (advance) begin
         ptr_reg <= (win_idx == PW'(N - 1)) ? '0 : win_idx + PW'(1);
      end
   end

endmodule

// File: rtl/ball_velocity_scheduler.sv
// Serialises velocity updates from several requesters onto the balls'
// write strobes, keeping writes off frame-tick cycles, and debounces the
// per-ball stop flags into allStopped, which gates the cue requester (0).
// Ports:
//   clk    system clock
//   reset  asynchronous active-high reset
//   bus    ball_velocity_scheduler_if.slave (requests, ball flags, outputs)
// The ball id width is fixed by billiard_pkg::BALL_ID_W.
module ball_velocity_scheduler
   import billiard_pkg::*;
#(
   parameter int NUM_REQ     = 4,
   parameter int NUM_BALLS   = 16,
   parameter int STOP_FRAMES = 8
) (
   input logic                      clk,
   input logic                      reset,
   ball_velocity_scheduler_if.slave bus
);

   localparam int CW = $clog2(STOP_FRAMES + 1);

   logic                 full_reg [NUM_REQ];
   vel_req_t             slot_reg [NUM_REQ];
   logic [NUM_REQ-1:0]   ready;
   logic [NUM_REQ-1:0]   eligible;
   logic [NUM_REQ-1:0]   grant;
   logic                 grant_any;
   vel_req_t             granted;

   logic [NUM_BALLS-1:0] vwe_reg, vwe_next;
   velocity_t            out_vx_reg, out_vy_reg;
   logic                 frame_tick_reg;
   logic                 bad_id_reg, bad_id_next;
   logic [CW-1:0]        cnt_reg, cnt_next;
   logic                 all_stopped_reg, all_stopped_next;

   genvar gi;

   // One-entry holding slot per requester. A slot cannot accept on the edge
   // it is granted because ready is still low then, so it always drains first.
   for (gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            full_reg[gi] <= 1'b0;
            slot_reg[gi] <= '0;
         end else if (grant[gi]) begin
            full_reg[gi] <= 1'b0;
         end else if (bus.reqValid[gi] && !full_reg[gi]) begin
            full_reg[gi] <= 1'b1;
            slot_reg[gi] <= '{id: bus.reqBallId[gi], vx: bus.reqVelX[gi], vy: bus.reqVelY[gi]};
         end
      end

      assign ready[gi] = !full_reg[gi];

      // Nothing is granted on a frame edge, so the strobe can never land
      // on the cycle the balls see frameTickOut.
      if (gi == 0) begin : g_cue
         assign eligible[gi] = full_reg[gi] && !bus.startOfFrame && all_stopped_reg;
      end else begin : g_other
         assign eligible[gi] = full_reg[gi] && !bus.startOfFrame;
      end
   end

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .clk     (clk),
      .reset   (reset),
      .req     (eligible),
      .advance (grant_any),
      .grant   (grant)
   );

   assign grant_any = |grant;

   always_comb begin
      granted = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (grant[i]) granted = slot_reg[i];
      end
   end

   // Out-of-range ids are consumed like any other grant but raise no strobe.
   for (gi = 0; gi < NUM_BALLS; gi++) begin : g_strobe
      assign vwe_next[gi] = grant_any && (int'(granted.id) == gi);
   end
   assign bad_id_next = grant_any && (int'(granted.id) >= NUM_BALLS);

   // Any velocity write means the table is no longer at rest, so a grant
   // overrides whatever the frame evaluation would have produced.
   always_comb begin
      cnt_next         = cnt_reg;
      all_stopped_next = all_stopped_reg;
      if (grant_any) begin
         cnt_next         = '0;
         all_stopped_next = 1'b0;
      end else if (bus.startOfFrame) begin
         if (&bus.ballStopped) begin
            cnt_next = (cnt_reg == CW'(STOP_FRAMES)) ? cnt_reg : cnt_reg + CW'(1);
         end else begin
            cnt_next = '0;
         end
         all_stopped_next = (cnt_next == CW'(STOP_FRAMES));
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vwe_reg         <= '0;
         out_vx_reg      <= '0;
         out_vy_reg      <= '0;
         frame_tick_reg  <= 1'b0;
         bad_id_reg      <= 1'b0;
         cnt_reg         <= '0;
         all_stopped_reg <= 1'b0;
      end else begin
         vwe_reg         <= vwe_next;
         bad_id_reg      <= bad_id_next;
         frame_tick_reg  <= bus.startOfFrame;
         cnt_reg         <= cnt_next;
         all_stopped_reg <= all_stopped_next;
         if (grant_any) begin
            out_vx_reg <= granted.vx;
            out_vy_reg <= granted.vy;
         end
      end
   end

   assign bus.reqReady            = ready;
   assign bus.velocityWriteEnable = vwe_reg;
   assign bus.outVelocityX        = out_vx_reg;
   assign bus.outVelocityY        = out_vy_reg;
   assign bus.frameTickOut        = frame_tick_reg;
   assign bus.allStopped          = all_stopped_reg;
   assign bus.badIdPulse          = bad_id_reg;

endmodule

// File: tb/tb_ball_velocity_scheduler.sv
// Self-checking bench for ball_velocity_scheduler with 4 requesters and
// 12 balls. Stimulus pushes the expected strobe into a queue; a negedge
// monitor pops and compares every observed strobe or bad-id pulse.
module tb_ball_velocity_scheduler;
   import billiard_pkg::*;

   localparam int NUM_REQ     = 4;
   localparam int NUM_BALLS   = 12;
   localparam int STOP_FRAMES = 8;

   typedef struct {
      int ball;
      int vx;
      int vy;
      int bad;
      int at;
   } exp_t;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   cyc    = 0;
   int   checks = 0;
   int   passed = 0;
   exp_t exp_q[$];
   exp_t mon_e;

   ball_velocity_scheduler_if #(.NUM_REQ(NUM_REQ), .NUM_BALLS(NUM_BALLS)) bus ();

   ball_velocity_scheduler #(
      .NUM_REQ     (NUM_REQ),
      .NUM_BALLS   (NUM_BALLS),
      .STOP_FRAMES (STOP_FRAMES)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_req(input int r, input int id, input int vx, input int vy);
      bus.reqValid[r]  = 1'b1;
      bus.reqBallId[r] = BALL_ID_W'(id);
      bus.reqVelX[r]   = VELOCITY_W'(vx);
      bus.reqVelY[r]   = VELOCITY_W'(vy);
   endtask

   task automatic expect_strobe(input int ball, input int vx, input int vy, input int bad, input int at);
      exp_t e;
      e.ball = ball; e.vx = vx; e.vy = vy; e.bad = bad; e.at = at;
      exp_q.push_back(e);
   endtask

   task automatic frame();
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
   endtask

   // Scoreboard monitor
   always @(negedge clk) begin
      if (!reset && (bus.velocityWriteEnable != '0 || bus.badIdPulse)) begin
         $display("strobe cycle=%0d vwe=%03h vx=%0d vy=%0d bad=%0b tick=%0b", cyc,
                  bus.velocityWriteEnable, bus.outVelocityX, bus.outVelocityY,
                  bus.badIdPulse, bus.frameTickOut);
         if (exp_q.size() == 0) begin
            chk("strobe_expected", exp_q.size(), 1);
         end else begin
            mon_e = exp_q.pop_front();
            chk("strobe_cycle", cyc, mon_e.at);
            chk("strobe_vec", int'(bus.velocityWriteEnable), (mon_e.bad != 0) ? 0 : (1 << mon_e.ball));
            chk("bad_id", int'(bus.badIdPulse), mon_e.bad);
            chk("vel_x", int'(bus.outVelocityX), mon_e.vx);
            chk("vel_y", int'(bus.outVelocityY), mon_e.vy);
            chk("tick_clash", int'(bus.frameTickOut), 0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.startOfFrame = 1'b0;
      bus.reqValid     = '0;
      bus.reqBallId    = '0;
      bus.reqVelX      = '0;
      bus.reqVelY      = '0;
      bus.ballStopped  = '0;
      repeat (2) tick();

      // Reset values
      chk("rst_ready",       int'(bus.reqReady), 15);
      chk("rst_vwe",         int'(bus.velocityWriteEnable), 0);
      chk("rst_vx",          int'(bus.outVelocityX), 0);
      chk("rst_vy",          int'(bus.outVelocityY), 0);
      chk("rst_tick",        int'(bus.frameTickOut), 0);
      chk("rst_bad",         int'(bus.badIdPulse), 0);
      chk("rst_all_stopped", int'(bus.allStopped), 0);
      reset = 1'b0;
      repeat (2) tick();

      // Single request: strobe two cycles after driving (one after accept)
      drive_req(1, 3, 40, -12);
      expect_strobe(3, 40, -12, 0, cyc + 2);
      tick();
      bus.reqValid = '0;
      chk("ready1_after_accept", int'(bus.reqReady[1]), 0);
      tick();
      chk("ready1_after_grant", int'(bus.reqReady[1]), 1);
      repeat (3) tick();

      // Frame clash: grant slips past the frame edge
      drive_req(2, 5, -100, 7);
      expect_strobe(5, -100, 7, 0, cyc + 3);
      tick();
      bus.reqValid     = '0;
      bus.startOfFrame = 1'b1;
      tick();
      bus.startOfFrame = 1'b0;
      chk("frame_tick_high",   int'(bus.frameTickOut), 1);
      chk("no_grant_on_frame", int'(bus.velocityWriteEnable), 0);
      tick();
      chk("frame_tick_low",    int'(bus.frameTickOut), 0);
      repeat (3) tick();

      // Fairness from pointer 0
      reset = 1'b1;
      tick();
      reset = 1'b0;
      tick();
      drive_req(1, 1, 10, -10);
      drive_req(2, 2, 20, -20);
      drive_req(3, 4, 30, -30);
      expect_strobe(1, 10, -10, 0, cyc + 2);
      expect_strobe(2, 20, -20, 0, cyc + 3);
      expect_strobe(4, 30, -30, 0, cyc + 4);
      tick();
      bus.reqValid = '0;
      tick();
      drive_req(1, 9, -1024, 1023);
      expect_strobe(9, -1024, 1023, 0, cyc + 3);
      tick();
      bus.reqValid = '0;
      repeat (4) tick();

      // Cue gating: held until allStopped after 8 frames
      bus.ballStopped = '1;
      drive_req(0, 0, 200, -200);
      tick();
      bus.reqValid = '0;
      for (int f = 1; f <= 7; f++) begin
         frame();
         chk($sformatf("cue_gate_f%0d", f), int'(bus.allStopped), 0);
         repeat (2) tick();
      end
      chk("cue_held", int'(bus.reqReady[0]), 0);
      expect_strobe(0, 200, -200, 0, cyc + 2);
      frame();
      chk("all_stopped_f8", int'(bus.allStopped), 1);
      tick();
      chk("all_stopped_after_cue", int'(bus.allStopped), 0);
      chk("cue_slot_free", int'(bus.reqReady[0]), 1);
      repeat (2) tick();

      // Debounce restart: ball 7 moving at frame 6
      for (int f = 1; f <= 14; f++) begin
         bus.ballStopped = (f == 6) ? 12'hF7F : 12'hFFF;
         frame();
         bus.ballStopped = '1;
         chk($sformatf("debounce_f%0d", f), int'(bus.allStopped), (f == 14) ? 1 : 0);
         repeat (2) tick();
      end

      // Out-of-range ball id
      drive_req(3, 15, -1, 1);
      expect_strobe(0, -1, 1, 1, cyc + 2);
      tick();
      bus.reqValid = '0;
      repeat (3) tick();
      chk("all_stopped_cleared_by_grant", int'(bus.allStopped), 0);

      // Reset while slot 2 is held behind a frame pulse
      drive_req(2, 6, 55, 66);
      bus.startOfFrame = 1'b1;
      tick();
      bus.reqValid = '0;
      chk("slot2_full", int'(bus.reqReady[2]), 0);
      reset = 1'b1;
      #1;
      chk("async_rst_ready", int'(bus.reqReady), 15);
      chk("async_rst_tick",  int'(bus.frameTickOut), 0);
      bus.startOfFrame = 1'b0;
      tick();
      reset = 1'b0;
      repeat (6) tick();
      chk("slot2_empty_after_reset", int'(bus.reqReady), 15);
      chk("queue_drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
